// File: rtl/pragmatic_term_scheduler_if.sv
// Input handshake bus of pragmatic_term_scheduler: one weight/activation vector per transfer.
// The producer uses the master modport and the scheduler uses the slave modport.
interface pragmatic_term_scheduler_if #(
    parameter int VEC_LENGTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                                  in_valid;
    logic                                  in_ready;
    logic                                  first_in;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weight_in;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_in;

    modport master (output in_valid, first_in, weight_in, act_in, input in_ready);
    modport slave  (input in_valid, first_in, weight_in, act_in, output in_ready);
endinterface

// File: rtl/pragmatic_term_scheduler.sv
// Essential-bit scheduler for one Pragmatic MAC: issues one power-of-two weight term per lane per cycle.
// Optional statistics counters are built only when PRAGMATIC_SCHED_STATS_EN is defined.
module pragmatic_term_scheduler #(
    parameter int VEC_LENGTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int STAT_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    pragmatic_term_scheduler_if.slave             in_if,
    output logic                                  mac_en,
    output logic                                  mac_load_accum,
    output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] mac_act,
    output logic [VEC_LENGTH-1:0][1:0]            mac_sh1_sel,
    output logic [VEC_LENGTH-1:0]                 mac_sh1_en,
    output logic [VEC_LENGTH-1:0]                 mac_is_neg,
    output logic [2:0]                            mac_sh2_sel,
    output logic                                  mac_sh2_en,
    output logic                                  result_valid,
    output logic [STAT_WIDTH-1:0]                 stat_run_cyc,
    output logic [STAT_WIDTH-1:0]                 stat_terms
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                            r_state;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] r_mask;
    logic [VEC_LENGTH-1:0]                 r_sign;
    logic                                  r_first;
    logic                                  r_first_step;

    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_abs;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_mask_next;
    logic [DATA_WIDTH-1:0]                 w_union;
    logic [2:0]                            w_base;
    logic                                  w_any;
    logic                                  w_run;
    logic [VEC_LENGTH-1:0][3:0]            w_win;
    logic [VEC_LENGTH-1:0][1:0]            w_sel;
    logic [VEC_LENGTH-1:0][2:0]            w_bit;
    logic [VEC_LENGTH-1:0]                 w_lane_en;

    // Magnitude as unsigned 8-bit: -128 wraps to 8'h80, which is exactly one term.
    always_comb begin
        for (int j = 0; j < VEC_LENGTH; j++) begin
            w_abs[j] = in_if.weight_in[j][DATA_WIDTH-1] ? (~in_if.weight_in[j] + 1'b1)
                                                         : in_if.weight_in[j];
        end
    end

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_union = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            w_union = w_union | r_mask[j];
        end
        w_base = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (w_union[i]) w_base = 3'(i);
        end
        w_any = |w_union;
    end

    // Each lane takes its lowest set bit inside the 4-bit window starting at the shared base.
    always_comb begin
        w_mask_next = r_mask;
        w_lane_en   = '0;
        w_win       = '0;
        w_sel       = '0;
        w_bit       = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            w_win[j] = 4'(r_mask[j] >> w_base);
            for (int k = 3; k >= 0; k--) begin
                if (w_win[j][k]) w_sel[j] = 2'(k);
            end
            w_bit[j] = w_base + {1'b0, w_sel[j]};
            if (w_win[j] != 4'd0) begin
                w_lane_en[j]   = 1'b1;
                w_mask_next[j] = r_mask[j] & ~(DATA_WIDTH'(1) << w_bit[j]);
            end
        end
    end

    assign w_run           = (r_state == S_RUN);
    assign in_if.in_ready  = (r_state == S_IDLE);
    assign mac_en          = w_run || (r_state == S_DRAIN);
    assign mac_sh2_en      = w_run && w_any;
    assign mac_sh2_sel     = w_run ? w_base : 3'd0;
    assign mac_sh1_en      = w_run ? w_lane_en : '0;
    assign mac_sh1_sel     = w_run ? w_sel : '0;
    assign mac_is_neg      = w_run ? (w_lane_en & r_sign) : '0;
    assign mac_load_accum  = w_run && r_first_step && r_first;
    assign result_valid    = (r_state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_sign       <= '0;
            r_first      <= 1'b0;
            r_first_step <= 1'b0;
            mac_act      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_if.in_valid) begin
                        r_mask       <= w_abs;
                        for (int j = 0; j < VEC_LENGTH; j++) begin
                            r_sign[j] <= in_if.weight_in[j][DATA_WIDTH-1];
                        end
                        mac_act      <= in_if.act_in;
                        r_first      <= in_if.first_in;
                        r_first_step <= 1'b1;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_mask       <= w_mask_next;
                    r_first_step <= 1'b0;
                    if (w_mask_next == '0) r_state <= S_DRAIN;
                end
                S_DRAIN: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PRAGMATIC_SCHED_STATS_EN
    logic [$clog2(VEC_LENGTH+1)-1:0] w_popcnt;
    logic [STAT_WIDTH-1:0]           r_stat_run_cyc;
    logic [STAT_WIDTH-1:0]           r_stat_terms;

    always_comb begin
        w_popcnt = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            w_popcnt = w_popcnt + $bits(w_popcnt)'(mac_sh1_en[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_run_cyc <= '0;
            r_stat_terms   <= '0;
        end else if (w_run) begin
            r_stat_run_cyc <= r_stat_run_cyc + 1'b1;
            r_stat_terms   <= r_stat_terms + STAT_WIDTH'(w_popcnt);
        end
    end

    assign stat_run_cyc = r_stat_run_cyc;
    assign stat_terms   = r_stat_terms;
`else
    assign stat_run_cyc = '0;
    assign stat_terms   = '0;
`endif

endmodule

// File: tb/tb_pragmatic_term_scheduler.sv
// Self-checking bench for pragmatic_term_scheduler: directed cases then random vectors,
// compared against a term-decomposition model and the exact dot product.
module tb_pragmatic_term_scheduler;

    localparam int VEC = 8;
    typedef logic [VEC-1:0][7:0] vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pragmatic_term_scheduler_if #(.VEC_LENGTH(VEC), .DATA_WIDTH(8)) bus ();

    logic                  mac_en, mac_load_accum, mac_sh2_en, result_valid;
    logic [VEC-1:0][7:0]   mac_act;
    logic [VEC-1:0][1:0]   mac_sh1_sel;
    logic [VEC-1:0]        mac_sh1_en, mac_is_neg;
    logic [2:0]            mac_sh2_sel;
    logic [31:0]           stat_run_cyc, stat_terms;

    pragmatic_term_scheduler #(.VEC_LENGTH(VEC), .DATA_WIDTH(8), .STAT_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_if          (bus),
        .mac_en         (mac_en),
        .mac_load_accum (mac_load_accum),
        .mac_act        (mac_act),
        .mac_sh1_sel    (mac_sh1_sel),
        .mac_sh1_en     (mac_sh1_en),
        .mac_is_neg     (mac_is_neg),
        .mac_sh2_sel    (mac_sh2_sel),
        .mac_sh2_en     (mac_sh2_en),
        .result_valid   (result_valid),
        .stat_run_cyc   (stat_run_cyc),
        .stat_terms     (stat_terms)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_run_cyc = '0;
    logic [31:0] exp_terms   = '0;

    // Expected schedule for the current vector.
    int                  m_n;
    int                  m_terms;
    int                  m_base [9];
    logic [VEC-1:0]      m_en   [9];
    logic [VEC-1:0][1:0] m_sel  [9];
    logic [VEC-1:0]      m_neg  [9];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Greedy decomposition on integer magnitudes: shared base = lowest remaining bit anywhere,
    // each lane retires its lowest remaining bit no more than 3 above the base.
    task automatic model(input vec_t w);
        int mag [VEC];
        int lo;
        for (int j = 0; j < VEC; j++) begin
            mag[j] = int'($signed(w[j]));
            if (mag[j] < 0) mag[j] = -mag[j];
        end
        m_n = 0;
        m_terms = 0;
        while (m_n < 9) begin
            lo = 8;
            for (int j = 0; j < VEC; j++)
                for (int b = 7; b >= 0; b--)
                    if (((mag[j] >> b) & 1) == 1 && b < lo) lo = b;
            if (lo == 8) begin
                if (m_n == 0) begin
                    m_base[0] = 0; m_en[0] = '0; m_sel[0] = '0; m_neg[0] = '0;
                    m_n = 1;
                end
                break;
            end
            m_base[m_n] = lo; m_en[m_n] = '0; m_sel[m_n] = '0; m_neg[m_n] = '0;
            for (int j = 0; j < VEC; j++) begin
                for (int b = lo; b <= lo + 3 && b <= 7; b++) begin
                    if (((mag[j] >> b) & 1) == 1) begin
                        m_en[m_n][j]  = 1'b1;
                        m_sel[m_n][j] = 2'(b - lo);
                        m_neg[m_n][j] = w[j][7];
                        mag[j] = mag[j] - (1 << b);
                        m_terms++;
                        break;
                    end
                end
            end
            m_n++;
        end
    endtask

    task automatic check_stats(input string name);
`ifdef PRAGMATIC_SCHED_STATS_EN
        check({name, ".stat_run"}, stat_run_cyc, exp_run_cyc);
        check({name, ".stat_terms"}, stat_terms, exp_terms);
`else
        check({name, ".stat_run"}, stat_run_cyc, 0);
        check({name, ".stat_terms"}, stat_terms, 0);
`endif
    endtask

    // abort_step >= 0 asserts reset during that RUN step and checks the recovery instead of completion.
    task automatic run_vec(input string name, input vec_t w, input vec_t a,
                           input logic first, input int abort_step);
        int dot_exp;
        int dot_got;
        int sh;
        model(w);
        dot_exp = 0;
        for (int j = 0; j < VEC; j++) dot_exp += int'($signed(w[j])) * int'($signed(a[j]));

        @(negedge clk);
        bus.in_valid = 1'b1; bus.weight_in = w; bus.act_in = a; bus.first_in = first;
        check({name, ".ready_idle"}, bus.in_ready, 1);
        @(negedge clk);
        // Garbage with in_valid high outside IDLE must be ignored.
        bus.weight_in = {$urandom, $urandom};
        bus.act_in    = {$urandom, $urandom};
        bus.first_in  = 1'($urandom);
        dot_got = 0;
        for (int k = 0; k < m_n; k++) begin
            check({name, ".run_mac_en"}, mac_en, 1);
            check({name, ".run_ready"}, bus.in_ready, 0);
            check({name, ".run_sh2_en"}, mac_sh2_en, (m_en[k] != '0));
            if (m_en[k] != '0) check({name, ".run_sh2_sel"}, mac_sh2_sel, m_base[k]);
            check({name, ".run_sh1_en"}, mac_sh1_en, m_en[k]);
            check({name, ".run_sh1_sel"}, mac_sh1_sel, m_sel[k]);
            check({name, ".run_is_neg"}, mac_is_neg, m_neg[k]);
            check({name, ".run_load"}, mac_load_accum, (k == 0) && first);
            check({name, ".run_act"}, mac_act, a);
            check({name, ".run_rv"}, result_valid, 0);
            for (int j = 0; j < VEC; j++) begin
                if (mac_sh1_en[j] && mac_sh2_en) begin
                    sh = int'(mac_sh1_sel[j]) + int'(mac_sh2_sel);
                    dot_got += int'($signed(mac_act[j])) * (1 << sh) * (mac_is_neg[j] ? -1 : 1);
                end
            end
            if (k == abort_step) begin
                reset = 1'b1; bus.in_valid = 1'b0;
                @(negedge clk);
                exp_run_cyc = '0; exp_terms = '0;
                check({name, ".rst_ready"}, bus.in_ready, 1);
                check({name, ".rst_mac_en"}, mac_en, 0);
                check({name, ".rst_rv"}, result_valid, 0);
                check({name, ".rst_sh1_en"}, mac_sh1_en, 0);
                check_stats({name, ".rst"});
                reset = 1'b0;
                return;
            end
            @(negedge clk);
        end
        exp_run_cyc += 32'(m_n);
        exp_terms   += 32'(m_terms);
        check({name, ".drain_mac_en"}, mac_en, 1);
        check({name, ".drain_sh2_en"}, mac_sh2_en, 0);
        check({name, ".drain_sh1_en"}, mac_sh1_en, 0);
        check({name, ".drain_rv"}, result_valid, 0);
        @(negedge clk);
        check({name, ".done_rv"}, result_valid, 1);
        check({name, ".done_mac_en"}, mac_en, 0);
        check({name, ".done_ready"}, bus.in_ready, 0);
        check({name, ".dot"}, 64'(dot_got), 64'(dot_exp));
        check_stats({name, ".done"});
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({name, ".after_rv"}, result_valid, 0);
        check({name, ".after_ready"}, bus.in_ready, 1);
        check({name, ".after_mac_en"}, mac_en, 0);
    endtask

    initial begin
        vec_t w;
        vec_t a;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.first_in = 1'b0; bus.weight_in = '0; bus.act_in = '0;
        repeat (2) @(negedge clk);
        check("reset.ready", bus.in_ready, 1);
        check("reset.mac_en", mac_en, 0);
        check("reset.rv", result_valid, 0);
        check("reset.act", mac_act, 0);
        check("reset.sh2_en", mac_sh2_en, 0);
        check("reset.load", mac_load_accum, 0);
        check_stats("reset");
        reset = 1'b0;

        w = {VEC{8'h01}}; a = {VEC{8'h01}};
        run_vec("t1_all_ones", w, a, 1'b1, -1);

        w = '0; w[0] = 8'h0F; a = {$urandom, $urandom};
        run_vec("t2_low_nibble", w, a, 1'b1, -1);

        w = '0; w[0] = 8'h11; w[1] = 8'h80; a = {VEC{8'h01}};
        run_vec("t3_min_neg", w, a, 1'b0, -1);

        w = '0; a = {$urandom, $urandom};
        run_vec("t4_zero", w, a, 1'b1, -1);

        w = {VEC{8'h03}}; a = {$urandom, $urandom};
        run_vec("t5_no_first", w, a, 1'b0, -1);

        w = '0; w[0] = 8'h0F; a = {$urandom, $urandom};
        run_vec("t6_abort", w, a, 1'b1, 1);

        w = {VEC{8'hFF}}; a = {$urandom, $urandom};
        run_vec("t6_recover", w, a, 1'b1, -1);

        for (int r = 0; r < 40; r++) begin
            for (int j = 0; j < VEC; j++) begin
                case ($urandom_range(0, 3))
                    0:       w[j] = 8'h00;
                    1:       w[j] = 8'($urandom);
                    2:       w[j] = 8'h80;
                    default: w[j] = 8'(1 << $urandom_range(0, 7));
                endcase
            end
            a = {$urandom, $urandom};
            run_vec("rand", w, a, 1'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
